// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - two-requester arbiter in front of a single-port RAM with 1-cycle read return
// Define SPRAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins); default is round-robin.
module spram_arbiter #(
  parameter int MEM_WIDTH  = 24,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [MEM_WIDTH-1:0]  din0,
  input  logic [MEM_WIDTH-1:0]  din1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [MEM_WIDTH-1:0]  rdata0,
  output logic [MEM_WIDTH-1:0]  rdata1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]  mem_din,
  input  logic [MEM_WIDTH-1:0]  mem_dout
);

  logic rd_pending;
  logic rd_owner;

`ifdef SPRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = req0;
    gnt1 = req1 & ~req0;
  end
`else
  // Index of the most recent grant; resets to 1 so requester 0 wins the first contention.
  logic last_grant;

  always_comb begin
    gnt0 = req0 & (~req1 | last_grant);
    gnt1 = req1 & ~gnt0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (gnt0 | gnt1) begin
      last_grant <= gnt1;
    end
  end
`endif

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (gnt0) begin
      mem_we   = we0;
      mem_addr = addr0;
      mem_din  = din0;
    end else if (gnt1) begin
      mem_we   = we1;
      mem_addr = addr1;
      mem_din  = din1;
    end
  end

  // A read issued while in reset is discarded because the flag is held clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      rd_pending <= (gnt0 | gnt1) & ~mem_we;
      if (gnt0 | gnt1) begin
        rd_owner <= gnt1;
      end
    end
  end

  always_comb begin
    rvalid0 = rd_pending & ~rd_owner;
    rvalid1 = rd_pending & rd_owner;
    rdata0  = rvalid0 ? mem_dout : '0;
    rdata1  = rvalid1 ? mem_dout : '0;
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - randomized self-checking bench for spram_arbiter with a RAM and transaction-level model
// Honours SPRAM_ARB_FIXED_PRIO_EN to select the expected arbitration policy.
module tb_spram_arbiter;
  localparam int MW = 24;
  localparam int AW = 8;
`ifdef SPRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [MW-1:0] din0, din1;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [MW-1:0] rdata0, rdata1, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;

  logic [MW-1:0] ram [256];
  logic [MW-1:0] ref_mem [256];

  int n_tests = 0;
  int n_fail = 0;

  // Model state: who was granted last, and the read expected to return next cycle.
  int m_last;
  bit m_rv;
  int m_rv_owner;
  logic [MW-1:0] m_rv_data;
  bit rst_cfg;
  logic [84:0] obs, expv;

  spram_arbiter #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  // Predict this cycle's outputs from the inputs and model state, then advance the model past the edge.
  task automatic settle();
    int last, win;
    bit rv;
    logic e_we;
    logic [AW-1:0] e_addr;
    logic [MW-1:0] e_din, e_rd0, e_rd1;
    #1;
    last = rst_n ? m_last : 1;
    rv = rst_n ? m_rv : 1'b0;
    win = -1;
    if (req0 && req1) win = FIXED ? 0 : 1 - last;
    else if (req0) win = 0;
    else if (req1) win = 1;
    e_we = 1'b0; e_addr = '0; e_din = '0;
    if (win == 0) begin e_we = we0; e_addr = addr0; e_din = din0; end
    if (win == 1) begin e_we = we1; e_addr = addr1; e_din = din1; end
    e_rd0 = (rv && m_rv_owner == 0) ? m_rv_data : '0;
    e_rd1 = (rv && m_rv_owner == 1) ? m_rv_data : '0;
    expv = {win == 0, win == 1, e_we, e_addr, e_din,
            rv && m_rv_owner == 0, e_rd0, rv && m_rv_owner == 1, e_rd1};
    obs = {gnt0, gnt1, mem_we, mem_addr, mem_din, rvalid0, rdata0, rvalid1, rdata1};
    if (!rst_n) begin
      m_last = 1;
      m_rv = 1'b0;
    end else begin
      m_rv = 1'b0;
      if (win >= 0) begin
        m_last = win;
        if (e_we) ref_mem[e_addr] = e_din;
        else begin
          m_rv = 1'b1;
          m_rv_owner = win;
          m_rv_data = ref_mem[e_addr];
        end
      end
    end
  endtask

  task automatic drive(input logic r0, w0, input logic [AW-1:0] a0, input logic [MW-1:0] d0,
                       input logic r1, w1, input logic [AW-1:0] a1, input logic [MW-1:0] d1);
    @(negedge clk);
    rst_n = rst_cfg;
    req0 = r0; we0 = w0; addr0 = a0; din0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; din1 = d1;
    settle();
  endtask

  task automatic test_reset();
    rst_cfg = 1'b0;
    drive(1, 0, 8'h05, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, (i == 0), 0, 8'h06, 0);
      n_tests++;
      if (obs !== expv || rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== '0 || rdata1 !== '0) begin
        n_fail++;
        $display("FAIL reset cyc%0d got %h want %h", i, obs, expv);
      end
    end
    rst_cfg = 1'b1;
  endtask

  task automatic test_write_read();
    drive(1, 1, 8'h10, 24'hABCDEF, 0, 0, 0, 0);
    n_tests++;
    if (gnt0 !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_din !== 24'hABCDEF ||
        rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || obs !== expv) begin
      n_fail++;
      $display("FAIL write_cmd got %h want %h", obs, expv);
    end
    drive(1, 0, 8'h10, 0, 0, 0, 0, 0);
    n_tests++;
    if (gnt0 !== 1'b1 || mem_we !== 1'b0 || rvalid0 !== 1'b0 || obs !== expv) begin
      n_fail++;
      $display("FAIL read_cmd got %h want %h", obs, expv);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (rvalid0 !== 1'b1 || rdata0 !== 24'hABCDEF || rvalid1 !== 1'b0 || obs !== expv) begin
      n_fail++;
      $display("FAIL read_return rvalid0=%b rdata0=%h want 1 abcdef", rvalid0, rdata0);
    end
  endtask

  task automatic test_alternating();
    rst_cfg = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_cfg = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive(1, 0, 8'(8'h20 + i), 0, 1, 0, 8'(8'h40 + i), 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      n_tests++;
      if (obs !== expv || (i < 6 && gnt1 !== (FIXED ? 1'b0 : 1'(i % 2)))) begin
        n_fail++;
        $display("FAIL alternating cyc%0d got %h want %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_single_burst();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(0, 0, 0, 0, 1, 0, 8'(i), 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      n_tests++;
      if (obs !== expv || (i < 4 && gnt1 !== 1'b1) || (i > 0 && rvalid1 !== 1'b1)) begin
        n_fail++;
        $display("FAIL single_burst cyc%0d got %h want %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_reset_drop();
    drive(1, 0, 8'h33, 0, 0, 0, 0, 0);
    rst_cfg = 1'b0;
    drive(1, 0, 8'h34, 0, 1, 0, 8'h35, 0);
    n_tests++;
    if (obs !== expv || gnt0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_grant got %h want %h", obs, expv);
    end
    rst_cfg = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      n_tests++;
      if (obs !== expv || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_drop cyc%0d rvalid0=%b rvalid1=%b want 0 0", i, rvalid0, rvalid1);
      end
    end
    drive(1, 1, 8'h36, 24'h1, 1, 1, 8'h37, 24'h2);
    n_tests++;
    if (obs !== expv || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL first_contention gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), 24'($urandom),
            1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), 24'($urandom));
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL random cyc%0d got %h want %h", i, obs, expv);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL random_drain got %h want %h", obs, expv);
    end
  endtask

`ifdef SPRAM_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    for (int i = 0; i < 6; i++) begin
      drive((i < 5), 0, 8'(i), 0, 1, 0, 8'(8'h80 + i), 0);
      n_tests++;
      if (obs !== expv || gnt0 !== (i < 5) || gnt1 !== (i == 5)) begin
        n_fail++;
        $display("FAIL fixed_prio cyc%0d gnt0=%b gnt1=%b", i, gnt0, gnt1);
      end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 24'(i * 37) ^ 24'h5A5A5A;
      ref_mem[i] = 24'(i * 37) ^ 24'h5A5A5A;
    end
    mem_dout = '0;
    m_last = 1; m_rv = 1'b0; m_rv_owner = 0; m_rv_data = '0;
    rst_cfg = 1'b0;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; din0 = 0; din1 = 0;
    test_reset();
    test_write_read();
    test_alternating();
    test_single_burst();
    test_reset_drop();
`ifdef SPRAM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
